// File: rtl/count_capture_pkg.sv
// Shared types and defaults for the count capture unit.
package count_capture_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/count_capture_unit_fifo.sv
// Capture FIFO: registered storage, valid/ready pop, drops pushes when full.
module capture_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = !empty && pop_ready;
  assign wr_en     = push && (!full || pop);
  assign drop_c    = push && full && !pop;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/count_capture_unit.sv
// Counter consumer: compare match FSM, wrap detection and triggered count capture.
module count_capture_unit
  import count_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] cmp_value,
  input  logic             cmp_periodic,
  input  logic             arm,
  input  logic             disarm,
  input  logic             trig_async,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_data,
  output logic             match_pulse,
  output logic             wrap_pulse,
  output logic             armed,
  output logic             ovf,
  input  logic             ovf_clr
);

  cmp_state_t       state;
  cmp_state_t       state_next;
  logic             match_next;
  logic             wrap_next;
  logic [CNT_W-1:0] prev_count;
  logic             sync1;
  logic             sync2;
  logic             sync3;
  logic [2:0]       fill;
  logic             push_q;
  logic             drop_c;

  // Compare FSM state register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  // Next state; disarm overrides arm and match.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = ARMED;
      ARMED:   if (count == cmp_value) state_next = FIRED;
      FIRED:   state_next = cmp_periodic ? ARMED : IDLE;
      default: state_next = IDLE;
    endcase
    if (disarm) state_next = IDLE;
  end

  // Output decode ahead of the output register.
  always_comb begin
    match_next = 1'b0;
    wrap_next  = 1'b0;
    if ((state == ARMED) && !disarm && (count == cmp_value)) match_next = 1'b1;
    if ((prev_count == '1) && (count == '0)) wrap_next = 1'b1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      match_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      armed       <= 1'b0;
      ovf         <= 1'b0;
      prev_count  <= '0;
    end else begin
      match_pulse <= match_next;
      wrap_pulse  <= wrap_next;
      armed       <= (state_next == ARMED);
      prev_count  <= count;
      if (drop_c)       ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Two-flop synchroniser plus edge-detect flop. fill gates edges until the
  // chain holds real samples, so a trigger already high at reset release is ignored.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      fill   <= '0;
      push_q <= 1'b0;
    end else begin
      sync1  <= trig_async;
      sync2  <= sync1;
      sync3  <= sync2;
      fill   <= {fill[1:0], 1'b1};
      push_q <= sync2 && !sync3 && fill[2];
    end
  end

  capture_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetN    (resetN),
    .push      (push_q),
    .push_data (count),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .drop_c    (drop_c)
  );

endmodule
